ctrl_pipe: RTL and testbench

CTRL_PIPE -- requirements
Module: ctrl_pipe

---
 rtl/ctrl_pkg.sv | 79 +++++++
 rtl/ctrl_pipe_if.sv | 46 ++++
 rtl/ctrl_pipe_hazard_unit.sv | 53 +++++
 rtl/ctrl_pipe.sv | 102 ++++++++++
 tb/tb_ctrl_pipe.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the control pipeline slice.
package ctrl_pkg;

  localparam int unsigned REG_W = 5;
  localparam int unsigned FWD_W = 2;

  // ALU operation encoding carried in alu_control.
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9,
    ALU_LUI  = 4'd10
  } alu_op_e;

  // Immediate format encoding carried in imm_sel.
  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4
  } imm_sel_e;

  // Writeback source encoding carried in mem_to_reg.
  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2
  } mem_to_reg_e;

  // EX operand source selects.
  localparam logic [FWD_W-1:0] FWD_RF  = 2'b00;
  localparam logic [FWD_W-1:0] FWD_MEM = 2'b01;
  localparam logic [FWD_W-1:0] FWD_WB  = 2'b10;

  // Decoded control bundle, 18 bits, MSB first.
  typedef struct packed {
    logic       load;
    logic       store;
    logic       jalr_out;
    logic [1:0] mem_to_reg;
    logic       reg_write;
    logic       mem_en;
    logic       operand_b;
    logic       operand_a;
    logic [2:0] imm_sel;
    logic       branch;
    logic       next_sel;
    logic [3:0] alu_control;
  } ctrl_bundle_t;

  // Contents of one pipeline stage register.
  typedef struct packed {
    logic             valid;
    ctrl_bundle_t     ctrl;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
  } stage_t;

  localparam stage_t STAGE_BUBBLE = '0;

  // Side-effecting fields read as zero for an invalid stage.
  function automatic ctrl_bundle_t gate_ctrl(input stage_t s);
    ctrl_bundle_t c;
    c           = s.ctrl;
    c.reg_write = s.ctrl.reg_write & s.valid;
    c.mem_en    = s.ctrl.mem_en & s.valid;
    return c;
  endfunction

endpackage

// File: rtl/ctrl_pipe_if.sv
// ID-side inputs and stage-side outputs of the control pipeline.
interface ctrl_pipe_if #(parameter int unsigned CNT_W = 16);
  import ctrl_pkg::*;

  logic               id_valid_i;
  ctrl_bundle_t       id_ctrl_i;
  logic [REG_W-1:0]   id_rd_i;
  logic [REG_W-1:0]   id_rs1_i;
  logic [REG_W-1:0]   id_rs2_i;
  logic               id_use_rs1_i;
  logic               id_use_rs2_i;
  logic               redirect_i;
  logic               ext_stall_i;

  ctrl_bundle_t       ex_ctrl_o;
  ctrl_bundle_t       mem_ctrl_o;
  ctrl_bundle_t       wb_ctrl_o;
  logic [REG_W-1:0]   ex_rd_o;
  logic [REG_W-1:0]   mem_rd_o;
  logic [REG_W-1:0]   wb_rd_o;
  logic               ex_valid_o;
  logic               mem_valid_o;
  logic               wb_valid_o;
  logic [FWD_W-1:0]   fwd_a_o;
  logic [FWD_W-1:0]   fwd_b_o;
  logic               stall_id_o;
  logic               flush_id_o;
  logic [CNT_W-1:0]   bubble_cnt_o;

  modport master (
    output id_valid_i, id_ctrl_i, id_rd_i, id_rs1_i, id_rs2_i,
           id_use_rs1_i, id_use_rs2_i, redirect_i, ext_stall_i,
    input  ex_ctrl_o, mem_ctrl_o, wb_ctrl_o, ex_rd_o, mem_rd_o, wb_rd_o,
           ex_valid_o, mem_valid_o, wb_valid_o, fwd_a_o, fwd_b_o,
           stall_id_o, flush_id_o, bubble_cnt_o
  );

  modport slave (
    input  id_valid_i, id_ctrl_i, id_rd_i, id_rs1_i, id_rs2_i,
           id_use_rs1_i, id_use_rs2_i, redirect_i, ext_stall_i,
    output ex_ctrl_o, mem_ctrl_o, wb_ctrl_o, ex_rd_o, mem_rd_o, wb_rd_o,
           ex_valid_o, mem_valid_o, wb_valid_o, fwd_a_o, fwd_b_o,
           stall_id_o, flush_id_o, bubble_cnt_o
  );

endinterface

// File: rtl/ctrl_pipe_hazard_unit.sv
// Combinational load-use detection and EX operand forwarding selection.
module hazard_unit
  import ctrl_pkg::*;
(
  input  logic             ex_valid,
  input  logic             ex_load,
  input  logic [REG_W-1:0] ex_rd,
  input  logic [REG_W-1:0] ex_rs1,
  input  logic [REG_W-1:0] ex_rs2,
  input  logic             mem_valid,
  input  logic             mem_reg_write,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             wb_valid,
  input  logic             wb_reg_write,
  input  logic [REG_W-1:0] wb_rd,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  output logic             load_use_c,
  output logic [FWD_W-1:0] fwd_a_c,
  output logic [FWD_W-1:0] fwd_b_c
);

  logic mem_writes_c;
  logic wb_writes_c;

  // MEM wins over WB; x0 never forwards.
  function automatic logic [FWD_W-1:0] fwd_sel(input logic [REG_W-1:0] src,
                                                input logic mem_wr,
                                                input logic wb_wr);
    logic [FWD_W-1:0] sel;
    sel = FWD_RF;
    if (mem_wr && (mem_rd == src)) begin
      sel = FWD_MEM;
    end else if (wb_wr && (wb_rd == src)) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

  // Producer qualifiers, then hazard and forward selects.
  always_comb begin
    mem_writes_c = mem_valid & mem_reg_write & (mem_rd != '0);
    wb_writes_c  = wb_valid & wb_reg_write & (wb_rd != '0);
    load_use_c   = ex_valid & ex_load & (ex_rd != '0) &
                   (((ex_rd == id_rs1) & id_use_rs1) |
                    ((ex_rd == id_rs2) & id_use_rs2));
    fwd_a_c      = fwd_sel(ex_rs1, mem_writes_c, wb_writes_c);
    fwd_b_c      = fwd_sel(ex_rs2, mem_writes_c, wb_writes_c);
  end

endmodule

// File: rtl/ctrl_pipe.sv
// EX/MEM/WB control stage registers with stall, flush and bubble accounting.
module ctrl_pipe
  import ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input logic       clk,
  input logic       rst_n,
  ctrl_pipe_if.slave bus
);

  localparam int unsigned N_STAGES = 3;
  localparam int unsigned S_EX     = 0;
  localparam int unsigned S_MEM    = 1;
  localparam int unsigned S_WB     = 2;

  stage_t           stage_q [N_STAGES];
  logic             redirect_pend_q;
  logic [CNT_W-1:0] bubble_cnt_q;

  logic             load_use_c;
  logic             redirect_c;
  logic             squash_c;
  stage_t           id_stage_c;

  hazard_unit u_hazard (
    .ex_valid      (stage_q[S_EX].valid),
    .ex_load       (stage_q[S_EX].ctrl.load),
    .ex_rd         (stage_q[S_EX].rd),
    .ex_rs1        (stage_q[S_EX].rs1),
    .ex_rs2        (stage_q[S_EX].rs2),
    .mem_valid     (stage_q[S_MEM].valid),
    .mem_reg_write (stage_q[S_MEM].ctrl.reg_write),
    .mem_rd        (stage_q[S_MEM].rd),
    .wb_valid      (stage_q[S_WB].valid),
    .wb_reg_write  (stage_q[S_WB].ctrl.reg_write),
    .wb_rd         (stage_q[S_WB].rd),
    .id_rs1        (bus.id_rs1_i),
    .id_rs2        (bus.id_rs2_i),
    .id_use_rs1    (bus.id_use_rs1_i),
    .id_use_rs2    (bus.id_use_rs2_i),
    .load_use_c    (load_use_c),
    .fwd_a_c       (bus.fwd_a_o),
    .fwd_b_c       (bus.fwd_b_o)
  );

  // Next EX contents: a redirect (live or held over a freeze) beats a load-use stall.
  always_comb begin
    redirect_c = bus.redirect_i | redirect_pend_q;
    squash_c   = redirect_c | load_use_c;
    id_stage_c = STAGE_BUBBLE;
    if (bus.id_valid_i && !squash_c) begin
      id_stage_c.valid = 1'b1;
      id_stage_c.ctrl  = bus.id_ctrl_i;
      id_stage_c.rd    = bus.id_rd_i;
      id_stage_c.rs1   = bus.id_rs1_i;
      id_stage_c.rs2   = bus.id_rs2_i;
    end
  end

  // Freeze, flush and stall handshake back to IF/ID.
  always_comb begin
    bus.stall_id_o = bus.ext_stall_i | (load_use_c & ~redirect_c);
    bus.flush_id_o = redirect_c & ~bus.ext_stall_i;
  end

  // Stage shift, redirect hold-over and saturating bubble counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N_STAGES; i++) begin
        stage_q[i] <= STAGE_BUBBLE;
      end
      redirect_pend_q <= 1'b0;
      bubble_cnt_q    <= '0;
    end else if (bus.ext_stall_i) begin
      redirect_pend_q <= redirect_pend_q | bus.redirect_i;
    end else begin
      stage_q[S_EX]   <= id_stage_c;
      stage_q[S_MEM]  <= stage_q[S_EX];
      stage_q[S_WB]   <= stage_q[S_MEM];
      redirect_pend_q <= 1'b0;
      if (squash_c && (bubble_cnt_q != '1)) begin
        bubble_cnt_q <= bubble_cnt_q + CNT_W'(1);
      end
    end
  end

  // Stage outputs; bundles masked by their valid bit.
  always_comb begin
    bus.ex_valid_o   = stage_q[S_EX].valid;
    bus.mem_valid_o  = stage_q[S_MEM].valid;
    bus.wb_valid_o   = stage_q[S_WB].valid;
    bus.ex_ctrl_o    = gate_ctrl(stage_q[S_EX]);
    bus.mem_ctrl_o   = gate_ctrl(stage_q[S_MEM]);
    bus.wb_ctrl_o    = gate_ctrl(stage_q[S_WB]);
    bus.ex_rd_o      = stage_q[S_EX].rd;
    bus.mem_rd_o     = stage_q[S_MEM].rd;
    bus.wb_rd_o      = stage_q[S_WB].rd;
    bus.bubble_cnt_o = bubble_cnt_q;
  end

endmodule

// File: tb/tb_ctrl_pipe.sv
// Self-checking bench: directed scenarios plus random stream against a queue model.
module tb_ctrl_pipe;
  import ctrl_pkg::*;

  logic             clk;
  logic             rst_n;
  logic             id_valid;
  ctrl_bundle_t     id_ctrl;
  logic [REG_W-1:0] id_rd, id_rs1, id_rs2;
  logic             use_rs1, use_rs2;
  logic             redirect, ext_stall;

  int unsigned n_vec;
  int unsigned n_err;

  // Model: queue front is EX, back is WB.
  stage_t      m_pipe [$];
  logic        m_pend;
  int unsigned m_cnt;

  ctrl_pipe_if #(.CNT_W(16)) bus16 ();
  ctrl_pipe_if #(.CNT_W(2))  bus2 ();

  ctrl_pipe #(.CNT_W(16)) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus16));
  ctrl_pipe #(.CNT_W(2))  u_dut_small (.clk(clk), .rst_n(rst_n), .bus(bus2));

  assign bus16.id_valid_i   = id_valid;
  assign bus16.id_ctrl_i    = id_ctrl;
  assign bus16.id_rd_i      = id_rd;
  assign bus16.id_rs1_i     = id_rs1;
  assign bus16.id_rs2_i     = id_rs2;
  assign bus16.id_use_rs1_i = use_rs1;
  assign bus16.id_use_rs2_i = use_rs2;
  assign bus16.redirect_i   = redirect;
  assign bus16.ext_stall_i  = ext_stall;
  assign bus2.id_valid_i    = id_valid;
  assign bus2.id_ctrl_i     = id_ctrl;
  assign bus2.id_rd_i       = id_rd;
  assign bus2.id_rs1_i      = id_rs1;
  assign bus2.id_rs2_i      = id_rs2;
  assign bus2.id_use_rs1_i  = use_rs1;
  assign bus2.id_use_rs2_i  = use_rs2;
  assign bus2.redirect_i    = redirect;
  assign bus2.ext_stall_i   = ext_stall;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic ctrl_bundle_t exp_ctrl(input stage_t s);
    ctrl_bundle_t c;
    c = s.ctrl;
    if (!s.valid) begin
      c.reg_write = 1'b0;
      c.mem_en    = 1'b0;
    end
    return c;
  endfunction

  function automatic logic [1:0] exp_fwd(input logic [REG_W-1:0] src);
    if (src == 0) return FWD_RF;
    if (m_pipe[1].valid && m_pipe[1].ctrl.reg_write && m_pipe[1].rd == src) return FWD_MEM;
    if (m_pipe[2].valid && m_pipe[2].ctrl.reg_write && m_pipe[2].rd == src) return FWD_WB;
    return FWD_RF;
  endfunction

  function automatic logic exp_hazard();
    stage_t e;
    e = m_pipe[0];
    return e.valid && e.ctrl.load && e.rd != 0 &&
           ((e.rd == id_rs1 && use_rs1) || (e.rd == id_rs2 && use_rs2));
  endfunction

  task automatic model_reset();
    m_pipe.delete();
    repeat (3) m_pipe.push_back(STAGE_BUBBLE);
    m_pend = 1'b0;
    m_cnt  = 0;
  endtask

  // Check current cycle, then advance model across the next edge.
  task automatic step();
    logic   hz;
    logic   redir;
    stage_t nxt;
    @(negedge clk);
    hz    = exp_hazard();
    redir = redirect | m_pend;
    check("ex_valid",  32'(bus16.ex_valid_o),  32'(m_pipe[0].valid));
    check("mem_valid", 32'(bus16.mem_valid_o), 32'(m_pipe[1].valid));
    check("wb_valid",  32'(bus16.wb_valid_o),  32'(m_pipe[2].valid));
    check("ex_ctrl",   32'(bus16.ex_ctrl_o),   32'(exp_ctrl(m_pipe[0])));
    check("mem_ctrl",  32'(bus16.mem_ctrl_o),  32'(exp_ctrl(m_pipe[1])));
    check("wb_ctrl",   32'(bus16.wb_ctrl_o),   32'(exp_ctrl(m_pipe[2])));
    check("ex_rd",     32'(bus16.ex_rd_o),     32'(m_pipe[0].rd));
    check("mem_rd",    32'(bus16.mem_rd_o),    32'(m_pipe[1].rd));
    check("wb_rd",     32'(bus16.wb_rd_o),     32'(m_pipe[2].rd));
    check("fwd_a",     32'(bus16.fwd_a_o),     32'(exp_fwd(m_pipe[0].rs1)));
    check("fwd_b",     32'(bus16.fwd_b_o),     32'(exp_fwd(m_pipe[0].rs2)));
    check("stall_id",  32'(bus16.stall_id_o),  32'(ext_stall | (hz & ~redir)));
    check("flush_id",  32'(bus16.flush_id_o),  32'(redir & ~ext_stall));
    check("bubble_cnt", 32'(bus16.bubble_cnt_o), (m_cnt > 65535) ? 32'd65535 : 32'(m_cnt));
    check("bubble_cnt_w2", 32'(bus2.bubble_cnt_o), (m_cnt > 3) ? 32'd3 : 32'(m_cnt));
    check("wb_ctrl_w2", 32'(bus2.wb_ctrl_o), 32'(exp_ctrl(m_pipe[2])));
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else if (ext_stall) begin
      m_pend = m_pend | redirect;
    end else begin
      nxt = STAGE_BUBBLE;
      if (redir || hz) m_cnt++;
      if (id_valid && !redir && !hz) begin
        nxt.valid = 1'b1;
        nxt.ctrl  = id_ctrl;
        nxt.rd    = id_rd;
        nxt.rs1   = id_rs1;
        nxt.rs2   = id_rs2;
      end
      m_pipe.push_front(nxt);
      void'(m_pipe.pop_back());
      m_pend = 1'b0;
    end
    #1;
  endtask

  task automatic set_id(input logic v, input ctrl_bundle_t c, input int rd,
                        input int rs1, input int rs2, input logic u1, input logic u2);
    id_valid = v;
    id_ctrl  = c;
    id_rd    = REG_W'(rd);
    id_rs1   = REG_W'(rs1);
    id_rs2   = REG_W'(rs2);
    use_rs1  = u1;
    use_rs2  = u2;
  endtask

  task automatic nop();
    set_id(1'b0, '0, 0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    nop();
    redirect  = 1'b0;
    ext_stall = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  ctrl_bundle_t c_alu, c_lw;

  initial begin
    n_vec = 0;
    n_err = 0;
    c_alu = '0;
    c_alu.reg_write   = 1'b1;
    c_alu.alu_control = ALU_ADD;
    c_lw  = '0;
    c_lw.load         = 1'b1;
    c_lw.reg_write    = 1'b1;
    c_lw.mem_en       = 1'b1;
    c_lw.mem_to_reg   = WB_MEM;
    c_lw.imm_sel      = IMM_I;

    rst_n = 1'b0;
    nop();
    redirect  = 1'b0;
    ext_stall = 1'b0;
    repeat (2) @(posedge clk);
    model_reset();
    #1;
    rst_n = 1'b1;

    // addi x1; add x2,x1,x1
    set_id(1'b1, c_alu, 1, 0, 0, 1'b1, 1'b0); step();
    set_id(1'b1, c_alu, 2, 1, 1, 1'b1, 1'b1); step();
    nop(); repeat (4) step();

    // lw x5; add x6,x5,x0 (add held in ID across the stall)
    do_reset();
    set_id(1'b1, c_lw, 5, 1, 0, 1'b1, 1'b0); step();
    set_id(1'b1, c_alu, 6, 5, 0, 1'b1, 1'b1); step(); step();
    nop(); repeat (3) step();
    check("lu_cnt_once", 32'(bus16.bubble_cnt_o), 32'd1);

    // lw x0; add x6,x0,x0
    do_reset();
    set_id(1'b1, c_lw, 0, 1, 0, 1'b1, 1'b0); step();
    set_id(1'b1, c_alu, 6, 0, 0, 1'b1, 1'b1); step();
    nop(); repeat (3) step();
    check("x0_no_bubble", 32'(bus16.bubble_cnt_o), 32'd0);

    // hazard and redirect together
    do_reset();
    set_id(1'b1, c_lw, 7, 1, 0, 1'b1, 1'b0); step();
    set_id(1'b1, c_alu, 8, 7, 7, 1'b1, 1'b1); redirect = 1'b1; step();
    redirect = 1'b0; nop(); repeat (3) step();
    check("flush_wins_cnt", 32'(bus16.bubble_cnt_o), 32'd1);

    // freeze for 3 cycles with a redirect arriving in the first
    do_reset();
    set_id(1'b1, c_alu, 3, 1, 2, 1'b1, 1'b1); step();
    set_id(1'b1, c_lw, 4, 3, 0, 1'b1, 1'b0); step();
    ext_stall = 1'b1; redirect = 1'b1; step();
    redirect = 1'b0; step(); step();
    check("frozen_cnt", 32'(bus16.bubble_cnt_o), 32'd0);
    ext_stall = 1'b0; set_id(1'b1, c_alu, 9, 1, 1, 1'b1, 1'b1); step();
    check("pend_redirect_cnt", 32'(bus16.bubble_cnt_o), 32'd1);
    nop(); repeat (3) step();

    // saturation: five redirect bubbles
    do_reset();
    set_id(1'b1, c_alu, 1, 0, 0, 1'b1, 1'b0);
    redirect = 1'b1; repeat (5) step();
    redirect = 1'b0; step();
    check("sat_w2", 32'(bus2.bubble_cnt_o), 32'd3);
    check("sat_w16", 32'(bus16.bubble_cnt_o), 32'd5);
    rst_n = 1'b0; step();
    rst_n = 1'b1; nop(); step();

    // random stream
    for (int i = 0; i < 600; i++) begin
      id_valid  = ($urandom % 8) != 0;
      id_ctrl   = ctrl_bundle_t'(18'($urandom));
      id_rd     = REG_W'($urandom % 4);
      id_rs1    = REG_W'($urandom % 4);
      id_rs2    = REG_W'($urandom % 4);
      use_rs1   = 1'($urandom);
      use_rs2   = 1'($urandom);
      redirect  = ($urandom % 8) == 0;
      ext_stall = ($urandom % 6) == 0;
      rst_n     = ($urandom % 50) != 0;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
